// File: rtl/exp_horner.sv
// Iterative fixed-point e^x using Horner's rule over a truncated Taylor series.
// One multiplier pair per step, two cycles per Taylor term, single-operand in flight.
module exp_horner #(
   parameter int DATA_WIDTH = 32,
   parameter int FRACTION   = 24,
   parameter int ORDER      = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_sat,
   output logic                  busy
);

   localparam int W2 = 2 * DATA_WIDTH;
   localparam logic [63:0] ONE64 = 64'd1 << FRACTION;
   localparam logic signed [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(ONE64);
   localparam logic signed [W2-1:0] MAX_W = $signed({{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
   localparam logic signed [W2-1:0] MIN_W = ~MAX_W;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t state_r, state_nxt;

   logic signed [DATA_WIDTH-1:0] x_r;
   logic signed [DATA_WIDTH-1:0] acc_r;
   logic signed [DATA_WIDTH-1:0] p_r;
   logic [3:0]                   k_r;
   logic                         phase_r;
   logic                         sat_r;

   function automatic logic signed [W2-1:0] sext(input logic signed [DATA_WIDTH-1:0] v);
      return $signed({{DATA_WIDTH{v[DATA_WIDTH-1]}}, v});
   endfunction

   // Full-width signed product, then arithmetic shift (floor) back to FRACTION bits.
   function automatic logic signed [W2-1:0] mul_shift(input logic signed [DATA_WIDTH-1:0] a,
                                                      input logic signed [DATA_WIDTH-1:0] b);
      logic signed [W2-1:0] prod;
      prod = sext(a) * sext(b);
      return prod >>> FRACTION;
   endfunction

   function automatic logic ovf_w(input logic signed [W2-1:0] v);
      return (v > MAX_W) || (v < MIN_W);
   endfunction

   function automatic logic signed [DATA_WIDTH-1:0] sat_w(input logic signed [W2-1:0] v);
      logic signed [W2-1:0] c;
      if (v > MAX_W)
         c = MAX_W;
      else if (v < MIN_W)
         c = MIN_W;
      else
         c = v;
      return c[DATA_WIDTH-1:0];
   endfunction

   // Reciprocal table floor(2^FRACTION/k); all divisions fold to constants.
   function automatic logic signed [DATA_WIDTH-1:0] recip(input logic [3:0] k);
      logic [63:0] r;
      case (k)
         4'd1:    r = ONE64;
         4'd2:    r = ONE64 / 64'd2;
         4'd3:    r = ONE64 / 64'd3;
         4'd4:    r = ONE64 / 64'd4;
         4'd5:    r = ONE64 / 64'd5;
         4'd6:    r = ONE64 / 64'd6;
         4'd7:    r = ONE64 / 64'd7;
         4'd8:    r = ONE64 / 64'd8;
         4'd9:    r = ONE64 / 64'd9;
         4'd10:   r = ONE64 / 64'd10;
         default: r = 64'd0;
      endcase
      return $signed(r[DATA_WIDTH-1:0]);
   endfunction

   logic signed [W2-1:0]         px_wide, pr_wide, sum_wide;
   logic signed [DATA_WIDTH-1:0] p_nxt, m_nxt, acc_nxt;
   logic                         p_ovf, m_ovf, a_ovf;
   logic                         last_step;

   always_comb begin
      px_wide   = mul_shift(x_r, acc_r);
      p_nxt     = sat_w(px_wide);
      p_ovf     = ovf_w(px_wide);
      pr_wide   = mul_shift(p_r, recip(k_r));
      m_nxt     = sat_w(pr_wide);
      m_ovf     = ovf_w(pr_wide);
      sum_wide  = sext(ONE) + sext(m_nxt);
      acc_nxt   = sat_w(sum_wide);
      a_ovf     = ovf_w(sum_wide);
      last_step = phase_r && (k_r == 4'd1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_r <= IDLE;
      else
         state_r <= state_nxt;
   end

   always_comb begin
      state_nxt = state_r;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_sat   = 1'b0;
      busy      = (state_r != IDLE);
      case (state_r)
         IDLE: begin
            in_ready = !rst;
            if (in_valid)
               state_nxt = CALC;
         end
         CALC: begin
            if (last_step)
               state_nxt = DONE;
         end
         DONE: begin
            out_valid = !rst;
            out_data  = rst ? '0 : acc_r;
            out_sat   = rst ? 1'b0 : sat_r;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: phase 0 forms x*acc, phase 1 scales by 1/k and adds 1.0.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_r     <= '0;
         acc_r   <= '0;
         p_r     <= '0;
         k_r     <= '0;
         phase_r <= 1'b0;
         sat_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  x_r     <= $signed(in_data);
                  acc_r   <= ONE;
                  k_r     <= 4'(ORDER);
                  phase_r <= 1'b0;
                  sat_r   <= 1'b0;
               end
            end
            CALC: begin
               if (!phase_r) begin
                  p_r     <= p_nxt;
                  phase_r <= 1'b1;
                  sat_r   <= sat_r | p_ovf;
               end else begin
                  phase_r <= 1'b0;
                  k_r     <= k_r - 4'd1;
                  if (last_step && acc_nxt[DATA_WIDTH-1]) begin
                     acc_r <= '0;
                     sat_r <= 1'b1;
                  end else begin
                     acc_r <= acc_nxt;
                     sat_r <= sat_r | m_ovf | a_ovf;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
